// File: rtl/ysyx_22050019_axi_pkg.sv
// Shared definitions for the AXI4-Lite SRAM bridge: response codes, FSM
// state encoding and the address window check.
package ysyx_22050019_axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_WAIT,
      ST_RD_RESP,
      ST_WR_WAIT,
      ST_WR_RESP
   } axi_state_e;

   // One extra bit keeps an address below base from wrapping into the window.
   function automatic logic axi_in_range(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input logic [63:0] size);
      logic [64:0] offset;
      offset = {1'b0, addr} - {1'b0, base};
      return offset < {1'b0, size};
   endfunction

endpackage

// File: rtl/ysyx_22050019_lat_cnt.sv
// Loadable 4-bit down-counter with a zero flag; times the wait between an
// AXI handshake and the memory strobe for both read and write paths.
module ysyx_22050019_lat_cnt (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic       zero
);

   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != 4'd0)) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/ysyx_22050019_axi_sram.sv
// AXI4-Lite slave in front of the physical memory model: one outstanding
// transaction, programmable strobe latency, registered responses.
module ysyx_22050019_axi_sram
   import ysyx_22050019_axi_pkg::*;
#(
   parameter int                ADDR_W = 32,
   parameter int                RD_LAT = 1,
   parameter int                WR_LAT = 1,
   parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000,
   parameter logic [ADDR_W-1:0] SIZE   = 32'h0800_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] araddr,
   input  logic              arvalid,
   output logic              arready,
   output logic [63:0]       rdata,
   output logic [1:0]        rresp,
   output logic              rvalid,
   input  logic              rready,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic              awvalid,
   output logic              awready,
   input  logic [63:0]       wdata,
   input  logic [7:0]        wstrb,
   input  logic              wvalid,
   output logic              wready,
   output logic [1:0]        bresp,
   output logic              bvalid,
   input  logic              bready,
   output logic              mem_ren,
   output logic [63:0]       mem_raddr,
   input  logic [63:0]       mem_rdata,
   output logic              mem_wen,
   output logic [63:0]       mem_waddr,
   output logic [63:0]       mem_wdata,
   output logic [7:0]        mem_mask
);

   localparam int          PAD_W    = 64 - ADDR_W;
   localparam logic [63:0] BASE_X   = {{PAD_W{1'b0}}, BASE};
   localparam logic [63:0] SIZE_X   = {{PAD_W{1'b0}}, SIZE};
   localparam logic [3:0]  RD_LAT_C = 4'(RD_LAT);
   localparam logic [3:0]  WR_LAT_C = 4'(WR_LAT);

   axi_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              range_q, range_d;
   logic [63:0]       wdata_q, wdata_d;
   logic [7:0]        wstrb_q, wstrb_d;
   logic [63:0]       rdata_q, rdata_d;
   logic [1:0]        rresp_q, rresp_d;
   logic [1:0]        bresp_q, bresp_d;
   logic              cnt_load, cnt_dec, cnt_zero;
   logic [3:0]        cnt_val;

   ysyx_22050019_lat_cnt u_lat_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      range_d  = range_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      bresp_d  = bresp_q;
      cnt_load = 1'b0;
      cnt_val  = 4'd0;
      cnt_dec  = 1'b0;
      arready  = 1'b0;
      awready  = 1'b0;
      wready   = 1'b0;
      mem_ren  = 1'b0;
      mem_wen  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            arready = 1'b1;
            // Reads take priority; a write needs AW and W in the same cycle.
            if (arvalid) begin
               addr_d   = araddr;
               range_d  = axi_in_range({{PAD_W{1'b0}}, araddr}, BASE_X, SIZE_X);
               cnt_load = 1'b1;
               cnt_val  = RD_LAT_C;
               state_d  = ST_RD_WAIT;
            end else if (awvalid && wvalid) begin
               awready  = 1'b1;
               wready   = 1'b1;
               addr_d   = awaddr;
               range_d  = axi_in_range({{PAD_W{1'b0}}, awaddr}, BASE_X, SIZE_X);
               wdata_d  = wdata;
               wstrb_d  = wstrb;
               cnt_load = 1'b1;
               cnt_val  = WR_LAT_C;
               state_d  = ST_WR_WAIT;
            end
         end
         ST_RD_WAIT: begin
            if (cnt_zero) begin
               mem_ren = range_q;
               rdata_d = range_q ? mem_rdata : 64'd0;
               rresp_d = range_q ? RESP_OKAY : RESP_SLVERR;
               state_d = ST_RD_RESP;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_RD_RESP: begin
            if (rready) state_d = ST_IDLE;
         end
         ST_WR_WAIT: begin
            if (cnt_zero) begin
               mem_wen = range_q && (wstrb_q != 8'd0);
               bresp_d = range_q ? RESP_OKAY : RESP_SLVERR;
               state_d = ST_WR_RESP;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_WR_RESP: begin
            if (bready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // A transaction caught by reset must never reach the memory.
      if (rst) begin
         arready = 1'b0;
         awready = 1'b0;
         wready  = 1'b0;
         mem_ren = 1'b0;
         mem_wen = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         range_q <= 1'b0;
         wdata_q <= 64'd0;
         wstrb_q <= 8'd0;
         rdata_q <= 64'd0;
         rresp_q <= RESP_OKAY;
         bresp_q <= RESP_OKAY;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         range_q <= range_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         rdata_q <= rdata_d;
         rresp_q <= rresp_d;
         bresp_q <= bresp_d;
      end
   end

   assign rvalid    = (state_q == ST_RD_RESP) && !rst;
   assign bvalid    = (state_q == ST_WR_RESP) && !rst;
   assign rdata     = rdata_q;
   assign rresp     = rresp_q;
   assign bresp     = bresp_q;
   assign mem_raddr = {{PAD_W{1'b0}}, addr_q};
   assign mem_waddr = {{PAD_W{1'b0}}, addr_q};
   assign mem_wdata = wdata_q;
   assign mem_mask  = wstrb_q;

endmodule

// File: tb/tb_ysyx_22050019_axi_sram.sv
// Self-checking bench for the AXI4-Lite SRAM bridge: directed scenarios
// followed by random reads/writes checked against a reference memory.
module tb_ysyx_22050019_axi_sram;

   localparam logic [63:0] BASE   = 64'h8000_0000;
   localparam logic [63:0] SIZE   = 64'h0800_0000;
   localparam int          RD_LAT = 1;
   localparam int          WR_LAT = 0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] araddr = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b0;
   logic [31:0] awaddr = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [63:0] wdata = '0;
   logic [7:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;
   logic        mem_ren;
   logic [63:0] mem_raddr;
   logic [63:0] mem_rdata;
   logic        mem_wen;
   logic [63:0] mem_waddr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_mask;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ysyx_22050019_axi_sram #(
      .ADDR_W (32),
      .RD_LAT (RD_LAT),
      .WR_LAT (WR_LAT),
      .BASE   (32'h8000_0000),
      .SIZE   (32'h0800_0000)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .araddr    (araddr),
      .arvalid   (arvalid),
      .arready   (arready),
      .rdata     (rdata),
      .rresp     (rresp),
      .rvalid    (rvalid),
      .rready    (rready),
      .awaddr    (awaddr),
      .awvalid   (awvalid),
      .awready   (awready),
      .wdata     (wdata),
      .wstrb     (wstrb),
      .wvalid    (wvalid),
      .wready    (wready),
      .bresp     (bresp),
      .bvalid    (bvalid),
      .bready    (bready),
      .mem_ren   (mem_ren),
      .mem_raddr (mem_raddr),
      .mem_rdata (mem_rdata),
      .mem_wen   (mem_wen),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata),
      .mem_mask  (mem_mask)
   );

   // phys stands in for the memory model and is written only by DUT strobes;
   // refMem is the bench's own view, updated when a write is issued.
   logic [63:0] phys   [0:255];
   logic [63:0] refMem [0:255];

   assign mem_rdata = phys[mem_raddr[10:3]];

   int          cyc = 0;
   int          renCnt = 0;
   int          wenCnt = 0;
   int          renCyc = -1;
   int          wenCyc = -1;
   int          bothHigh = 0;
   logic [63:0] wenAddr = '0;
   logic [63:0] wenData = '0;
   logic [7:0]  wenMask = '0;

   // Log every memory strobe with the cycle it was high in and apply writes.
   always @(posedge clk) begin
      if (mem_ren === 1'b1) begin
         renCnt <= renCnt + 1;
         renCyc <= cyc;
      end
      if (mem_wen === 1'b1) begin
         wenCnt  <= wenCnt + 1;
         wenCyc  <= cyc;
         wenAddr <= mem_waddr;
         wenData <= mem_wdata;
         wenMask <= mem_mask;
         for (int b = 0; b < 8; b++) begin
            if (mem_mask[b]) phys[mem_waddr[10:3]][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
      if ((mem_ren === 1'b1) && (mem_wen === 1'b1)) bothHigh <= bothHigh + 1;
      cyc <= cyc + 1;
   end

   // Hard stop if something wedges beyond every bounded wait.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic refInRange(input logic [63:0] a);
      return (a >= BASE) && (a < BASE + SIZE);
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Full read: AR handshake, latency check, data/resp check, optional hold.
   task automatic applyStimulusRead(input logic [63:0] a, input int hold, input string tag);
      int          n;
      int          tHs;
      int          ren0;
      logic        ok;
      logic [63:0] expD;
      logic [1:0]  expR;
      ok   = refInRange(a);
      expD = ok ? refMem[a[10:3]] : 64'd0;
      expR = ok ? 2'b00 : 2'b10;
      ren0 = renCnt;
      araddr  = a[31:0];
      arvalid = 1'b1;
      #1;
      n = 0;
      while ((arready !== 1'b1) && (n < 40)) begin
         @(negedge clk); #1; n++;
      end
      checkOutput({tag, "_arready"}, 64'(arready), 64'd1);
      tHs = cyc;
      @(negedge clk);
      arvalid = 1'b0;
      n = 0;
      while ((rvalid !== 1'b1) && (n < 40)) begin
         @(negedge clk); n++;
      end
      checkOutput({tag, "_rvalid_cyc"}, 64'(cyc), 64'(tHs + 2 + RD_LAT));
      checkOutput({tag, "_rdata"}, rdata, expD);
      checkOutput({tag, "_rresp"}, 64'(rresp), 64'(expR));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         checkOutput({tag, "_hold_rvalid"}, 64'(rvalid), 64'd1);
         checkOutput({tag, "_hold_rdata"}, rdata, expD);
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      checkOutput({tag, "_ren_count"}, 64'(renCnt - ren0), ok ? 64'd1 : 64'd0);
      if (ok) checkOutput({tag, "_ren_cyc"}, 64'(renCyc), 64'(tHs + 1 + RD_LAT));
   endtask

   // Full write; waitCycles reports how many cycles AW/W waited for ready.
   task automatic applyStimulusWrite(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                                     input string tag, output int waitCycles);
      int   n;
      int   tHs;
      int   wen0;
      logic ok;
      logic strobe;
      ok     = refInRange(a);
      strobe = ok && (s != 8'd0);
      wen0   = wenCnt;
      awaddr  = a[31:0];
      wdata   = d;
      wstrb   = s;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      #1;
      n = 0;
      while ((awready !== 1'b1) && (n < 40)) begin
         @(negedge clk); #1; n++;
      end
      waitCycles = n;
      checkOutput({tag, "_awready"}, 64'(awready), 64'd1);
      checkOutput({tag, "_wready"}, 64'(wready), 64'd1);
      tHs = cyc;
      if (strobe) begin
         for (int b = 0; b < 8; b++) begin
            if (s[b]) refMem[a[10:3]][8*b +: 8] = d[8*b +: 8];
         end
      end
      @(negedge clk);
      awvalid = 1'b0;
      wvalid  = 1'b0;
      n = 0;
      while ((bvalid !== 1'b1) && (n < 40)) begin
         @(negedge clk); n++;
      end
      checkOutput({tag, "_bvalid_cyc"}, 64'(cyc), 64'(tHs + 2 + WR_LAT));
      checkOutput({tag, "_bresp"}, 64'(bresp), ok ? 64'd0 : 64'd2);
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      checkOutput({tag, "_wen_count"}, 64'(wenCnt - wen0), strobe ? 64'd1 : 64'd0);
      if (strobe) begin
         checkOutput({tag, "_wen_cyc"}, 64'(wenCyc), 64'(tHs + 1 + WR_LAT));
         checkOutput({tag, "_wen_addr"}, wenAddr, a);
         checkOutput({tag, "_wen_data"}, wenData, d);
         checkOutput({tag, "_wen_mask"}, 64'(wenMask), 64'(s));
      end
   endtask

   initial begin
      int          n;
      int          tRd;
      int          tWr;
      int          ren0;
      int          wen0;
      logic [63:0] v;
      logic [63:0] a;
      logic [63:0] expD;
      int          sel;

      for (int i = 0; i < 256; i++) begin
         v = {$urandom, $urandom};
         phys[i]   = v;
         refMem[i] = v;
      end
      phys[2]   = 64'h1122_3344_5566_7788;
      refMem[2] = 64'h1122_3344_5566_7788;

      // Reset values while reset is held.
      repeat (3) @(negedge clk);
      checkOutput("rst_arready", 64'(arready), 64'd0);
      checkOutput("rst_awready", 64'(awready), 64'd0);
      checkOutput("rst_wready", 64'(wready), 64'd0);
      checkOutput("rst_rvalid", 64'(rvalid), 64'd0);
      checkOutput("rst_bvalid", 64'(bvalid), 64'd0);
      checkOutput("rst_mem_ren", 64'(mem_ren), 64'd0);
      checkOutput("rst_mem_wen", 64'(mem_wen), 64'd0);
      checkOutput("rst_rdata", rdata, 64'd0);
      checkOutput("rst_rresp", 64'(rresp), 64'd0);
      checkOutput("rst_bresp", 64'(bresp), 64'd0);
      checkOutput("rst_mem_raddr", mem_raddr, 64'd0);
      checkOutput("rst_mem_wdata", mem_wdata, 64'd0);
      checkOutput("rst_mem_mask", 64'(mem_mask), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("idle_arready", 64'(arready), 64'd1);

      // Basic read with rdata held for three cycles of backpressure.
      applyStimulusRead(64'h8000_0010, 3, "rd_basic");

      // Partial write then read back: only the low word changes.
      expD = {refMem[1][63:32], 32'hCAFE_BABE};
      applyStimulusWrite(64'h8000_0008, 64'hDEAD_BEEF_CAFE_BABE, 8'h0F, "wr_basic", n);
      checkOutput("wr_basic_model", refMem[1], expD);
      applyStimulusRead(64'h8000_0008, 0, "rd_back");

      // Lone AW must never be acknowledged; W arriving completes it at once.
      awaddr  = 32'h8000_0030;
      awvalid = 1'b1;
      wvalid  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); #1;
         checkOutput("split_awready", 64'(awready), 64'd0);
         checkOutput("split_wready", 64'(wready), 64'd0);
      end
      applyStimulusWrite(64'h8000_0030, 64'h0123_4567_89AB_CDEF, 8'hFF, "wr_split", n);
      checkOutput("split_same_cycle", 64'(n), 64'd0);

      // Read and write offered together: read first, write right after R.
      ren0 = renCnt;
      wen0 = wenCnt;
      expD = refMem[8];
      araddr  = 32'h8000_0040;
      arvalid = 1'b1;
      awaddr  = 32'h8000_0048;
      wdata   = 64'hA5A5_0000_5A5A_FFFF;
      wstrb   = 8'hFF;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      #1;
      checkOutput("col_arready", 64'(arready), 64'd1);
      checkOutput("col_awready", 64'(awready), 64'd0);
      tRd = cyc;
      @(negedge clk);
      arvalid = 1'b0;
      #1;
      checkOutput("col_aw_blocked", 64'(awready), 64'd0);
      n = 0;
      while ((rvalid !== 1'b1) && (n < 40)) begin
         @(negedge clk); n++;
      end
      checkOutput("col_rvalid_cyc", 64'(cyc), 64'(tRd + 2 + RD_LAT));
      checkOutput("col_rdata", rdata, expD);
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      #1;
      checkOutput("col_aw_after_r", 64'(awready), 64'd1);
      checkOutput("col_w_after_r", 64'(wready), 64'd1);
      tWr = cyc;
      refMem[9] = 64'hA5A5_0000_5A5A_FFFF;
      @(negedge clk);
      awvalid = 1'b0;
      wvalid  = 1'b0;
      n = 0;
      while ((bvalid !== 1'b1) && (n < 40)) begin
         @(negedge clk); n++;
      end
      checkOutput("col_bvalid_cyc", 64'(cyc), 64'(tWr + 2 + WR_LAT));
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      checkOutput("col_ren_once", 64'(renCnt - ren0), 64'd1);
      checkOutput("col_wen_once", 64'(wenCnt - wen0), 64'd1);
      applyStimulusRead(64'h8000_0048, 0, "col_rd_back");

      // Window edges on both sides, plus suppressed writes.
      applyStimulusRead(64'h7FFF_FFFC, 0, "rng_below");
      applyStimulusRead(64'h8800_0000, 0, "rng_above");
      applyStimulusRead(64'h87FF_FFF8, 0, "rng_top");
      applyStimulusRead(64'h8000_0000, 0, "rng_base");
      applyStimulusWrite(64'h8800_0000, 64'h1111_2222_3333_4444, 8'hFF, "wr_oor", n);
      applyStimulusWrite(64'h8000_0050, 64'h5555_6666_7777_8888, 8'h00, "wr_nostrb", n);

      // Reset in the strobe cycle of a pending read drops it entirely.
      ren0 = renCnt;
      araddr  = 32'h8000_0020;
      arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midrst_arready_low", 64'(arready), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_arready", 64'(arready), 64'd1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput("midrst_rvalid", 64'(rvalid), 64'd0);
      end
      checkOutput("midrst_no_ren", 64'(renCnt - ren0), 64'd0);

      // Random traffic against the reference memory.
      for (int k = 0; k < 30; k++) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 7)       a = BASE + 64'($urandom_range(0, 255)) * 64'd8;
         else if (sel == 7) a = BASE - 64'(8 * $urandom_range(1, 4));
         else               a = BASE + SIZE + 64'(8 * $urandom_range(0, 4));
         if ($urandom_range(0, 1) == 1) begin
            applyStimulusRead(a, int'($urandom_range(0, 2)), "rnd_rd");
         end else begin
            applyStimulusWrite(a, {$urandom, $urandom}, 8'($urandom_range(0, 255)), "rnd_wr", n);
         end
      end

      checkOutput("strobes_exclusive", 64'(bothHigh), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
